// File: rtl/switch_port_ingress.sv
// Per-port ingress stage: classifies packets, queues valid ones in a FIFO and routes
// each queued packet to its target outputs. Optional build macro: INGRESS_SELF_FILTER_EN.
module switch_port_ingress #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int PORT_ID    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_pkt,
    output logic [3:0]                 req_o,
    input  logic [3:0]                 gnt_i,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_pkt,
    output logic [3:0]                 out_dest,
    output logic [1:0]                 out_type,
    output logic [1:0]                 state_o,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [7:0]                 err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [3:0]    SELF_MASK = 4'(1 << PORT_ID);
`ifdef INGRESS_SELF_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'b00, ROUTE = 2'b01, ARB_WAIT = 2'b10, TRANSMIT = 2'b11} state_t;
    typedef enum logic [1:0] {P_ERR = 2'b00, P_SDP = 2'b01, P_MDP = 2'b10, P_BDP = 2'b11} ptype_t;

    function automatic ptype_t classify(input logic [3:0] src, input logic [3:0] tgt);
        if (tgt == 4'b0000 || !$onehot(src)) return P_ERR;
        case ($countones(tgt))
            1:       return P_SDP;
            4:       return P_BDP;
            default: return P_MDP;
        endcase
    endfunction

    state_t                  state, state_nx;
    ptype_t                  in_type, ptype;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic [DATA_WIDTH-1:0]   head, wr_pkt;
    logic [3:0]              in_src, in_tgt, pending, served;
    logic                    accept, push, pop, drop;

    // Incoming packet fields; the stored packet carries the filtered target.
    assign in_src  = in_pkt[DATA_WIDTH-1 -: 4];
    assign in_tgt  = FILTER_EN ? (in_pkt[DATA_WIDTH-5 -: 4] & ~SELF_MASK) : in_pkt[DATA_WIDTH-5 -: 4];
    assign in_type = classify(in_src, in_tgt);
    assign wr_pkt  = {in_src, in_tgt, in_pkt[DATA_WIDTH-9:0]};

    assign in_ready   = (count < DEPTH_C);
    assign accept     = in_valid && in_ready;
    assign push       = accept && (in_type != P_ERR);
    assign drop       = accept && (in_type == P_ERR);
    assign pop        = (state == IDLE) && (count != '0);
    assign fifo_count = count;
    assign state_o    = state;

    // NOTE: storage array carries no reset; only pointers and count define validity,
    // which keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_pkt;
    end

    // NOTE: every sequential assignment uses <= so all registers update from the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (drop && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Per-packet routing context: head packet, outputs still owed, outputs won this round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            pending <= '0;
            served  <= '0;
            ptype   <= P_ERR;
        end else begin
            case (state)
                IDLE:     if (pop) head <= mem[rd_ptr];
                ROUTE: begin
                    pending <= head[DATA_WIDTH-5 -: 4];
                    ptype   <= classify(head[DATA_WIDTH-1 -: 4], head[DATA_WIDTH-5 -: 4]);
                end
                ARB_WAIT: if ((gnt_i & pending) != 4'b0000) served <= gnt_i & pending;
                TRANSMIT: pending <= pending & ~served;
                default:  ;
            endcase
        end
    end

    // NOTE: all outputs of this block get a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        req_o     = 4'b0000;
        out_valid = 1'b0;
        out_pkt   = '0;
        out_dest  = 4'b0000;
        out_type  = P_ERR;
        case (state)
            IDLE:  if (count != '0) state_nx = ROUTE;
            ROUTE: state_nx = ARB_WAIT;
            ARB_WAIT: begin
                req_o = pending;
                if ((gnt_i & pending) != 4'b0000) state_nx = TRANSMIT;
            end
            TRANSMIT: begin
                out_valid = 1'b1;
                out_pkt   = head;
                out_dest  = served;
                out_type  = ptype;
                state_nx  = ((pending & ~served) == 4'b0000) ? IDLE : ARB_WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_switch_port_ingress.sv
// Self-checking bench for switch_port_ingress: directed scenarios plus randomized
// traffic scored against a transaction-level queue model.
module tb_switch_port_ingress;

`ifdef INGRESS_SELF_FILTER_EN
    localparam bit SELF_FILTER = 1'b1;
`else
    localparam bit SELF_FILTER = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_pkt = '0;
    logic [3:0]  req_o;
    logic [3:0]  gnt_i = '0;
    logic        out_valid;
    logic [15:0] out_pkt;
    logic [3:0]  out_dest;
    logic [1:0]  out_type;
    logic [1:0]  state_o;
    logic [3:0]  fifo_count;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: accepted packets in order (stored with filtered target), outputs still owed
    // by the front packet, and the expected error count.
    logic [15:0] q[$];
    logic [3:0]  rem;
    bit          started;
    int          err_m;

    switch_port_ingress #(.DATA_WIDTH(16), .DEPTH(DEPTH), .PORT_ID(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
        .req_o(req_o), .gnt_i(gnt_i), .out_valid(out_valid), .out_pkt(out_pkt),
        .out_dest(out_dest), .out_type(out_type), .state_o(state_o),
        .fifo_count(fifo_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        gnt_i    = 4'b0000;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        started = 1'b0;
        rem     = '0;
        err_m   = 0;
    endtask

    function automatic int bits(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [1:0] exp_type(input logic [3:0] tgt);
        case (bits(tgt))
            1:       return 2'b01;
            4:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_accept(input logic [15:0] pkt);
        logic [3:0] tgt;
        tgt = pkt[11:8];
        if (SELF_FILTER) tgt[0] = 1'b0;
        if (bits(pkt[15:12]) != 1 || tgt == 4'b0000) begin
            if (err_m < 255) err_m++;
        end else begin
            q.push_back({pkt[15:12], tgt, pkt[7:0]});
        end
    endtask

    // Checks the current cycle's outputs; gnt_i still holds the grant of the previous cycle.
    task automatic observe();
        logic [3:0] dest_x;
        check("ready_vs_count", in_ready, fifo_count < 4'(DEPTH));
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", out_valid, 1'b0);
            end else begin
                if (!started) begin
                    rem     = q[0][11:8];
                    started = 1'b1;
                end
                dest_x = gnt_i & rem;
                check("out_pkt", out_pkt, q[0]);
                check("out_dest", out_dest, dest_x);
                check("out_type", out_type, exp_type(q[0][11:8]));
                rem = rem & ~dest_x;
                if (rem == 4'b0000 || dest_x == 4'b0000) begin
                    void'(q.pop_front());
                    started = 1'b0;
                end
            end
        end
        if (req_o != 4'b0000)
            check("req_o", req_o, (q.size() == 0) ? 4'b0000 : (started ? rem : q[0][11:8]));
    endtask

    task automatic drain(input int budget);
        in_valid = 1'b0;
        gnt_i    = 4'hF;
        for (int k = 0; k < budget && (q.size() != 0 || state_o != 2'b00); k++) begin
            step();
            observe();
        end
        check("drain_complete", q.size(), 0);
    endtask

    task automatic send_one(input logic [15:0] pkt);
        in_valid = 1'b1;
        in_pkt   = pkt;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic        acc;
        logic [15:0] p;
        logic [3:0]  src;
        bit          saw_valid;

        // Reset values, observed while rst_n is held low.
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_req", req_o, 4'b0000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pkt", out_pkt, 16'h0000);
        check("rst_out_dest", out_dest, 4'b0000);
        check("rst_out_type", out_type, 2'b00);
        check("rst_state", state_o, 2'b00);
        check("rst_fifo_count", fifo_count, 4'd0);
        check("rst_err_count", err_count, 8'd0);
        apply_reset();

        // Unicast latency: accepted in N, ROUTE N+2, request N+3, transmit N+4.
        gnt_i = 4'b0010;
        send_one(16'h1255);
        check("uni_n1_count", fifo_count, 4'd1);
        step();
        check("uni_n2_state", state_o, 2'b01);
        check("uni_n2_req", req_o, 4'b0000);
        step();
        check("uni_n3_state", state_o, 2'b10);
        check("uni_n3_req", req_o, 4'b0010);
        check("uni_n3_valid", out_valid, 1'b0);
        step();
        check("uni_n4_valid", out_valid, 1'b1);
        check("uni_n4_pkt", out_pkt, 16'h1255);
        check("uni_n4_dest", out_dest, 4'b0010);
        check("uni_n4_type", out_type, 2'b01);
        check("uni_n4_req", req_o, 4'b0000);
        step();
        check("uni_n5_state", state_o, 2'b00);
        check("uni_n5_valid", out_valid, 1'b0);

        // Staggered multicast to 0110.
        gnt_i = 4'b0000;
        send_one(16'h16AA);
        step();
        step();
        check("mc_req_full", req_o, 4'b0110);
        gnt_i = 4'b0100;
        step();
        check("mc_tx1_valid", out_valid, 1'b1);
        check("mc_tx1_dest", out_dest, 4'b0100);
        check("mc_tx1_type", out_type, 2'b10);
        check("mc_tx1_pkt", out_pkt, 16'h16AA);
        gnt_i = 4'b0000;
        step();
        check("mc_req_rest", req_o, 4'b0010);
        check("mc_wait_valid", out_valid, 1'b0);
        gnt_i = 4'b0010;
        step();
        check("mc_tx2_valid", out_valid, 1'b1);
        check("mc_tx2_dest", out_dest, 4'b0010);
        check("mc_tx2_type", out_type, 2'b10);
        gnt_i = 4'b0000;
        step();
        check("mc_idle", state_o, 2'b00);

        // ERR drops: empty target, then non-one-hot source.
        send_one(16'h10FF);
        in_valid = 1'b1;
        in_pkt   = 16'h3211;
        step();
        in_valid = 1'b0;
        check("err_count_2", err_count, 8'd2);
        check("err_fifo_0", fifo_count, 4'd0);
        step();
        check("err_req_0", req_o, 4'b0000);
        check("err_state", state_o, 2'b00);

        // Self-filter: packet addressed only to port 0.
        apply_reset();
        gnt_i = 4'b0001;
        send_one(16'h2100);
        step();
        step();
        step();
        if (SELF_FILTER) begin
            check("self_err", err_count, 8'd1);
            check("self_no_valid", out_valid, 1'b0);
            check("self_fifo", fifo_count, 4'd0);
        end else begin
            check("hairpin_valid", out_valid, 1'b1);
            check("hairpin_dest", out_dest, 4'b0001);
            check("hairpin_pkt", out_pkt, 16'h2100);
            check("hairpin_err", err_count, 8'd0);
        end

        // err_count saturation.
        apply_reset();
        in_valid = 1'b1;
        in_pkt   = 16'h3211;
        for (int i = 0; i < 257; i++) step();
        in_valid = 1'b0;
        check("err_saturate", err_count, 8'd255);
        check("err_sat_fifo", fifo_count, 4'd0);

        // Fill and backpressure, then drain in order.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            observe();
            p        = {4'b0001 << (i % 4), 4'($urandom_range(1, 7)) << 1, 8'(i)};
            in_valid = 1'b1;
            in_pkt   = p;
            acc      = in_ready;
            step();
            if (acc) model_accept(p);
        end
        in_valid = 1'b0;
        observe();
        check("full_count", fifo_count, 4'd8);
        check("full_ready", in_ready, 1'b0);
        check("full_model_size", q.size(), 9);
        drain(300);
        check("drained_ready", in_ready, 1'b1);
        check("drained_count", fifo_count, 4'd0);

        // Reset during ARB_WAIT with three packets queued.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pkt   = {4'b0010, 4'b0100, 8'(i)};
            step();
        end
        in_valid = 1'b0;
        check("mid_pre_state", state_o, 2'b10);
        check("mid_pre_count", fifo_count, 4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_req", req_o, 4'b0000);
        check("mid_count", fifo_count, 4'd0);
        check("mid_state", state_o, 2'b00);
        gnt_i = 4'hF;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        check("mid_no_tx_after_reset", saw_valid, 1'b0);

        // Randomized traffic against the queue model.
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            observe();
            src      = ($urandom_range(0, 3) != 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            p        = {src, 4'($urandom), 8'($urandom)};
            in_valid = ($urandom_range(0, 2) != 0);
            in_pkt   = p;
            gnt_i    = 4'($urandom);
            acc      = in_valid && in_ready;
            step();
            if (acc) model_accept(p);
        end
        observe();
        drain(400);
        check("rand_err_count", err_count, 8'(err_m));
        check("rand_final_count", fifo_count, 4'd0);
        check("rand_final_state", state_o, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/switch_port_ingress.md
# switch_port_ingress

Per-port input stage of the 4-port packet switch. It accepts 16-bit packets (`source[15:12]`, `target[11:8]`, `data[7:0]`) from the port driver and classifies each one as ERR, SDP, MDP or BDP. Valid packets are buffered in an 8-entry FIFO. A routing FSM (IDLE/ROUTE/ARB_WAIT/TRANSMIT) then requests the output arbiters and hands the packet to each granted output, feeding the switch core downstream.

## Interface
- `DATA_WIDTH`, default 16: packet width.
- `DEPTH`, default 8: FIFO entries (power of two).
- `PORT_ID`, default 0: this port's index, 0..3.
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: an upstream packet is present.
- `in_ready` output, 1 bit: the FIFO can accept a packet.
- `in_pkt` input, DATA_WIDTH bits: the packet `{source, target, data}`.
- `req_o` output, 4 bits: per-output request, one bit per destination.
- `gnt_i` input, 4 bits: per-output grant from the arbiters.
- `out_valid` output, 1 bit: `out_pkt` is being delivered this cycle.
- `out_pkt` output, DATA_WIDTH bits: the packet being transmitted.
- `out_dest` output, 4 bits: outputs served this cycle.
- `out_type` output, 2 bits: `p_type` encoding, ERR=00, SDP=01, MDP=10, BDP=11.
- `state_o` output, 2 bits: FSM state, IDLE=00, ROUTE=01, ARB_WAIT=10, TRANSMIT=11.
- `fifo_count` output, $clog2(DEPTH)+1 bits: current occupancy.
- `err_count` output, 8 bits: count of dropped ERR packets.

## Operation
- **Classification** (combinational on `in_pkt`), with `effective target` = `target` after the optional self-filter:
  - ERR if the effective target is 0000, or if `source` is not one-hot.
  - SDP if exactly 1 target bit is set.
  - MDP if 2 or 3 target bits are set.
  - BDP if all 4 target bits are set.
- **Accept:** a packet is accepted on `in_valid && in_ready`.
  - Non-ERR packets are written to the FIFO with the effective target.
  - ERR packets are dropped, and `err_count` increments, saturating at 255.
- **Backpressure:** `in_ready = (fifo_count < DEPTH)`. ERR packets also need `in_ready` to be accepted.
- **IDLE:** if the FIFO is non-empty, pop the head into the head register and go to ROUTE.
- **ROUTE:** `pending` ← head target, `type` ← classification; go to ARB_WAIT.
- **ARB_WAIT:**
  - `req_o = pending`.
  - If `(gnt_i & pending) != 0`, latch `served = gnt_i & pending` and go to TRANSMIT.
  - Otherwise hold.
  - Grant bits outside `pending` are ignored.
- **TRANSMIT:**
  - `out_valid = 1`, `out_pkt` = head, `out_dest = served`, `out_type` = type.
  - `pending` ← `pending & ~served`.
  - If the new `pending` is 0, go to IDLE; otherwise go to ARB_WAIT.
- MDP and BDP packets can therefore be delivered over several TRANSMIT cycles. The outputs served across those cycles are disjoint and together equal the target.
- `req_o` is 0 in every state except ARB_WAIT.

## Timing
- **Reset values:**
  - `in_ready` = 1.
  - `req_o` = 0, `out_valid` = 0, `out_pkt` = 0, `out_dest` = 0, `out_type` = 00.
  - `state_o` = IDLE, `fifo_count` = 0, `err_count` = 0.
- **Latency:** for a packet accepted in cycle N into an empty FIFO with the FSM in IDLE:
  - Pop at the end of N+1.
  - ROUTE in N+2.
  - ARB_WAIT in N+3, with `req_o` asserted.
  - If granted in N+3, TRANSMIT with `out_valid` in N+4.
- All outputs are registered or decoded from registered state. No input reaches `req_o` or `out_*` combinationally.
- **Simultaneous write and pop:** `fifo_count` is unchanged. The FIFO pointers wrap modulo DEPTH.
- **Full FIFO:** `in_ready` = 0 and `in_valid` is ignored. `in_ready` rises the cycle after a pop.
- **`err_count` at 255:** it stays at 255.
- **Reset mid-operation:** the FIFO is flushed and the in-flight packet is lost. No partial TRANSMIT follows the release of `rst_n`.

## Configuration
- **`INGRESS_SELF_FILTER_EN` defined:** the target bit `[PORT_ID]` is cleared before classification. A packet addressed only to its own port becomes ERR and is dropped.
- **`INGRESS_SELF_FILTER_EN` undefined:** the target is used unmodified, so hairpin delivery to `PORT_ID` is allowed.

## Test plan
- **Unicast:** PORT_ID=0; send 0x1255 with `gnt_i` = 0010 held.
  - Required: `req_o` = 0010 in N+3; `out_valid` in N+4 with `out_pkt` = 0x1255, `out_dest` = 0010, `out_type` = 01.
- **Staggered multicast:** send 0x16AA (target 0110); grant 0100 first, then 0010 two cycles later.
  - Required: two TRANSMIT cycles with `out_dest` = 0100 then 0010; `out_type` = 10; IDLE afterwards.
- **ERR drops:** send 0x10FF (target 0) and 0x3211 (source not one-hot).
  - Required: both dropped; `err_count` = 2; `fifo_count` stays 0; `req_o` stays 0.
- **Full and backpressure:** hold `gnt_i` = 0 and send 10 valid packets.
  - Required: `fifo_count` reaches 8 and `in_ready` = 0. Then grant all outputs and confirm FIFO order is preserved and `in_ready` returns to 1.
- **Self-filter:** PORT_ID=0, macro defined; send 0x2100.
  - Required: dropped, `err_count` = 1. With the macro undefined: delivered with `out_dest` = 0001.
- **Reset mid-operation:** assert `rst_n` = 0 during ARB_WAIT with 3 packets queued.
  - Required: immediately `req_o` = 0, `fifo_count` = 0, `state_o` = IDLE; no `out_valid` after the release of `rst_n`.
